// File: rtl/conv_acc_bias_int32_if.sv
// conv_acc_bias_int32_if: activation/weight input stream and int32 result stream
interface conv_acc_bias_int32_if #(parameter int ACC_W = 32);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_act;
  logic [7:0]       in_wgt;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  modport master (output in_valid, in_act, in_wgt, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_act, in_wgt, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/conv_acc_bias_int32.sv
// conv_acc_bias_int32: zero-point corrected int8 MAC over cfg_len terms plus bias, int32 result.
// ACC_SAT_EN: saturate accumulate and bias add instead of wrapping.
module conv_acc_bias_int32 #(
  parameter int LEN_W = 12,
  parameter int ACC_W = 32
) (
  input  logic                 sclk,
  input  logic                 s_rst_n,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [ACC_W-1:0]     cfg_bias,
  input  logic [7:0]           cfg_zp,
  conv_acc_bias_int32_if.slave io,
  output logic                 busy
);
  typedef enum logic [2:0] {IDLE, ACC, DRAIN, BIAS, OUT} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, prod_q, prod_d, out_data_q, out_data_d, bias_q, bias_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [7:0]       zp_q, zp_d, zp_use;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d, accept;
  logic signed [8:0]  diff;
  logic signed [16:0] prod;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
`ifdef ACC_SAT_EN
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    return (s[ACC_W] != s[ACC_W-1]) ? {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : s[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction

  always_comb begin
    accept      = io.in_valid && in_ready_q;
    // the first beat of a group is corrected with the live zero point, later beats with the latched one
    zp_use      = (state_q == IDLE) ? cfg_zp : zp_q;
    diff        = $signed({1'b0, io.in_act}) - $signed({1'b0, zp_use});
    prod        = 17'(diff) * 17'($signed(io.in_wgt));
    prod_d      = accept ? {{(ACC_W-17){prod[16]}}, prod} : '0;
    acc_d       = (state_q == ACC || state_q == DRAIN) ? acc_add(acc_q, prod_q) : acc_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    bias_d      = bias_q;
    zp_d        = zp_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (accept) begin
        len_d   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        bias_d  = cfg_bias;
        zp_d    = cfg_zp;
        acc_d   = '0;
        cnt_d   = LEN_W'(1);
        state_d = (cfg_len <= LEN_W'(1)) ? DRAIN : ACC;
      end
      ACC: if (accept) begin
        cnt_d   = cnt_q + LEN_W'(1);
        state_d = (cnt_q + LEN_W'(1) == len_q) ? DRAIN : ACC;
      end
      DRAIN: state_d = BIAS;
      BIAS: begin
        out_data_d  = acc_add(acc_q, bias_q);
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: if (io.out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE) || (state_d == ACC);
    busy_d     = state_d != IDLE;
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      bias_q      <= '0;
      zp_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      bias_q      <= bias_d;
      zp_q        <= zp_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign busy         = busy_q;
endmodule
